// File: rtl/param_fifo_pkg.sv
// Shared defaults and types for the param_fifo block.
package param_fifo_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefAddrW = 4;
   localparam int unsigned DefAfLvl = (2 ** DefAddrW) - 2;
   localparam int unsigned DefAeLvl = 2;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

endpackage

// File: rtl/param_fifo_ctrl.sv
// Pointer, occupancy, flag decode and acceptance logic for param_fifo.
// Sticky error flags exist only when PARAM_FIFO_ERR_EN is defined.
module param_fifo_ctrl
   import param_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned AF_LVL = DefAfLvl,
   parameter int unsigned AE_LVL = DefAeLvl
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              clear_err_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_ptr_o,
   output logic [ADDR_W-1:0] rd_ptr_o,
   output logic [ADDR_W:0]   count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [ADDR_W:0]   DepthC  = (ADDR_W + 1)'(2 ** ADDR_W);
   localparam logic [ADDR_W:0]   AfLvlC  = (ADDR_W + 1)'(AF_LVL);
   localparam logic [ADDR_W:0]   AeLvlC  = (ADDR_W + 1)'(AE_LVL);
   localparam logic [ADDR_W:0]   CntOneC = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PtrOneC = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty, full;
   logic              push_acc, pop_acc;

   assign empty = (count_q == '0);
   assign full  = (count_q == DepthC);

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
   assign push_acc = push_i & (~full | pop_i);
   assign pop_acc  = pop_i & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PtrOneC;
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PtrOneC;
      end
      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CntOneC;
         2'b01:   count_d = count_q - CntOneC;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_en_o        = push_acc;
   assign wr_ptr_o       = wr_ptr_q;
   assign rd_ptr_o       = rd_ptr_q;
   assign count_o        = count_q;
   assign empty_o        = empty;
   assign full_o         = full;
   assign almost_full_o  = (count_q >= AfLvlC);
   assign almost_empty_o = (count_q <= AeLvlC);

`ifdef PARAM_FIFO_ERR_EN
   err_flags_t err_q, err_d;

   // Set is applied after clear so a same-cycle set wins.
   always_comb begin
      err_d = err_q;
      if (clear_err_i) begin
         err_d = '0;
      end
      if (push_i && full && !pop_i) begin
         err_d.overflow = 1'b1;
      end
      if (pop_i && empty) begin
         err_d.underflow = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign overflow_o  = err_q.overflow;
   assign underflow_o = err_q.underflow;
`else
   logic unused_clear_err;
   assign unused_clear_err = clear_err_i;
   assign overflow_o       = 1'b0;
   assign underflow_o      = 1'b0;
`endif

endmodule

// File: rtl/param_fifo.sv
// Parameterised first-word-fall-through FIFO with occupancy flags.
// Define PARAM_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned AF_LVL = (2 ** ADDR_W) - 2,
   parameter int unsigned AE_LVL = DefAeLvl
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overflow_o,
   output logic              underflow_o,
   input  logic              clear_err_i
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];
   logic              wr_en;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;

   param_fifo_ctrl #(
      .ADDR_W (ADDR_W),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
   ) u_ctrl (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .push_i         (push_i),
      .pop_i          (pop_i),
      .clear_err_i    (clear_err_i),
      .wr_en_o        (wr_en),
      .wr_ptr_o       (wr_ptr),
      .rd_ptr_o       (rd_ptr),
      .count_o        (count_o),
      .empty_o        (empty_o),
      .full_o         (full_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   // Storage has no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= push_data_i;
      end
   end

   assign pop_data_o = mem_q[rd_ptr];

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo with a queue-based reference model.
module tb_param_fifo;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clr = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic [DW-1:0] pop_data;
   logic          empty, full, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]   count;

   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];
   int            mcount = 0;
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   param_fifo #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .AF_LVL (AF),
      .AE_LVL (AE)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .push_i         (push),
      .push_data_i    (push_data),
      .pop_i          (pop),
      .pop_data_o     (pop_data),
      .empty_o        (empty),
      .full_o         (full),
      .almost_full_o  (almost_full),
      .almost_empty_o (almost_empty),
      .count_o        (count),
      .overflow_o     (overflow),
      .underflow_o    (underflow),
      .clear_err_i    (clr)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(mcount));
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("full", 32'(full), 32'(mcount == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mcount >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(mcount <= AE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      if (mcount > 0) chk("head", 32'(pop_data), 32'(exp_q[0]));
   endtask

   // One cycle: check the state the last edge produced, then issue new stimulus.
   task automatic step(input bit p, input logic [DW-1:0] d, input bit q, input bit c);
      bit push_ok, pop_ok;
      @(posedge clk);
      #1;
      check_state();
      push      = p;
      push_data = d;
      pop       = q;
      clr       = c;
      push_ok   = p && ((mcount < DEPTH) || q);
      pop_ok    = q && (mcount > 0);
`ifdef PARAM_FIFO_ERR_EN
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && mcount == DEPTH && !q) m_ovf = 1'b1;
      if (q && mcount == 0) m_unf = 1'b1;
`endif
      if (push_ok) exp_q.push_back(d);
      mcount = mcount + int'(push_ok) - int'(pop_ok);
   endtask

   task automatic do_reset_midstream();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      clr   = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      exp_q.delete();
      mcount = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted pop must deliver the oldest outstanding word.
   always @(negedge clk) begin
      if (rst_n && pop && !empty) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL pop_underrun: got 0x%0h, want no pop accepted at %0t", pop_data, $time);
         end else begin
            chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #12;
      chk("init_count", 32'(count), 32'd0);
      chk("init_empty", 32'(empty), 32'd1);
      chk("init_full", 32'(full), 32'd0);
      chk("init_almost_empty", 32'(almost_empty), 32'd1);
      chk("init_almost_full", 32'(almost_full), 32'd0);
      chk("init_overflow", 32'(overflow), 32'd0);
      chk("init_underflow", 32'(underflow), 32'd0);
      #1;
      rst_n = 1'b1;

      // Fill to full, then drain in order.
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      step(0, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // Fall-through latency into an empty FIFO.
      step(1, 8'hA5, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0);

      // Push and pop together while full.
      for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
      step(1, 8'h55, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

      // Overflow on a push-only into a full FIFO, then clear.
      for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0);
      step(1, 8'h66, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

      // Push and pop together while empty.
      step(1, 8'h77, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 1);

      // Pointer wrap over six rounds.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + r * 3 + i), 0, 0);
         for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
      end

      // Random traffic with alternating fill and drain bias.
      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = ((i / 25) % 2 == 0) ? 75 : 25;
         step(($urandom_range(0, 99) < bias), 8'($urandom),
              ($urandom_range(0, 99) >= bias), ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in the middle of traffic.
      step(1, 8'hE1, 0, 0);
      step(1, 8'hE2, 1, 0);
      do_reset_midstream();

      // First push after reset release.
      step(1, 8'h99, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
